block_stream_reader: RTL and testbench
======================================

BLOCK_STREAM_READER -- requirements
Module: block_stream_reader

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32, width of one block in bits.
REQ-002 SHALL have parameter NUM_BLOCKS, default 128, number of blocks per frame; must match the attached block store.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, return-buffer entries; legal values are 3 or more.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk_in  input  1  the single clock; all logic is on its rising edge.
REQ-006 rst_in  input  1  asynchronous, active-low reset.
REQ-007 start_in  input  1  one-cycle pulse that starts a frame; accepted only in IDLE.
REQ-008 busy_out  output  1  high whenever the state is not IDLE.
REQ-009 read_next_block_valid_out  output  1  registered read-advance pulse to the block store, one pulse per block.
REQ-010 read_block_in  input  REGISTER_SIZE  block data returned by the store.
REQ-011 read_block_valid_in  input  1  qualifies read_block_in; arrives exactly 2 cycles after each read pulse.
REQ-012 block_out  output  REGISTER_SIZE  downstream block; equals the FIFO head.
REQ-013 block_valid_out  output  1  high when the FIFO is not empty.
REQ-014 block_ready_in  input  1  downstream ready; a transfer occurs when valid and ready are both high.
REQ-015 block_last_out  output  1  high together with block_valid_out on block NUM_BLOCKS-1 of the frame.
REQ-016 done_out  output  1  one-cycle pulse in the cycle after the last block transfers.
REQ-017 abort_in  input  1  requests early termination of the frame; the port exists only with the macro of REQ-036.

Function
REQ-018 States SHALL be IDLE, STREAM, DRAIN and FLUSH; FLUSH exists only with the macro.
REQ-019 Transition: IDLE -> STREAM on start_in; the first read pulse is asserted in the next cycle.
REQ-020 In STREAM, a read pulse is issued when issued_count < NUM_BLOCKS and (occupancy + in_flight) < FIFO_DEPTH; pop credit in the same cycle is not counted.
REQ-021 Transition: STREAM -> DRAIN after pulse number NUM_BLOCKS; DRAIN issues no further pulses.
REQ-022 Transition: DRAIN -> IDLE when in_flight = 0, the FIFO is empty and the last block has transferred; done_out is pulsed.
REQ-023 in_flight counter SHALL increment on each issued pulse and decrement on each read_block_valid_in; both in one cycle leaves it unchanged; its range is 0..2.
REQ-024 Each returned block is pushed into the FIFO, with write data registered; block_valid_out rises 1 cycle after read_block_valid_in.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged; a push into a full FIFO is impossible by REQ-020 and is flagged by an assertion.
REQ-026 Latency: start_in at cycle 0 -> read pulse at cycle 1 -> read_block_valid_in at cycle 3 -> block_valid_out at cycle 4.
REQ-027 With block_ready_in held high, throughput SHALL be one block per cycle after the initial latency.
REQ-028 block_out and block_last_out SHALL hold stable while valid is high and ready is low.
REQ-029 issued_count and the delivered block counter SHALL be $clog2(NUM_BLOCKS)+1 bits wide and clear on each accepted start_in.
REQ-030 start_in outside IDLE SHALL be ignored.
REQ-031 read_block_valid_in while in IDLE is a protocol error; the data is discarded.
REQ-032 Exactly NUM_BLOCKS pulses are issued per frame, so the store's read address wraps back to 0 at frame end.

Reset
REQ-033 Assertion of rst_in (low) SHALL immediately force state IDLE and clear all counters and the FIFO pointers.
REQ-034 During reset, every output (block_out, block_valid_out, block_last_out, read_next_block_valid_out, busy_out, done_out) SHALL be 0.
REQ-035 Reset mid-frame abandons the frame; the block store must be reset together with this block.

Configuration
REQ-036 Macro BLOCK_READER_ABORT_EN defined: abort_in exists; abort in STREAM or DRAIN goes to FLUSH.
REQ-037 FLUSH behaviour: issue the remaining pulses up to NUM_BLOCKS at one per cycle, drop all returns and FIFO contents, hold block_valid_out at 0, then go to IDLE when in_flight = 0; done_out is not pulsed.
REQ-038 Macro undefined: no abort_in port and no FLUSH state.

Verification
REQ-039 Scenario, NUM_BLOCKS=8, ready=1: start -> pulses at cycles 1-8, blocks 0-7 at cycles 4-11, last at cycle 11, done at cycle 12.
REQ-040 Scenario, ready=0 for 10 cycles after start: exactly FIFO_DEPTH pulses are issued, then none until ready returns; no data is lost or reordered.
REQ-041 Scenario, random ready at 50%, NUM_BLOCKS=128: 128 transfers in order, a single last flag, the store address ends at 0.
REQ-042 Scenario, start_in pulsed again during STREAM: ignored, and the frame completes normally.
REQ-043 Scenario, rst_in low at cycle 6 of a frame: all outputs read 0 immediately; a new start then runs a clean frame.
REQ-044 Scenario, with BLOCK_READER_ABORT_EN, abort at block 3 of 8: 8 pulses in total, no valid after the abort, IDLE afterwards, no done_out.

Source files
------------

// File: rtl/block_stream_reader.sv
// block_stream_reader: reads one frame of NUM_BLOCKS blocks from an attached
// block store (fixed 2-cycle read latency) and streams them downstream through
// a small return FIFO with valid/ready flow control.
// Optional feature: define BLOCK_READER_ABORT_EN to add abort_in and the FLUSH state.
//
// Handshakes: a downstream transfer happens on every rising edge where
// block_valid_out and block_ready_in are both high. block_out/block_last_out
// hold steady while valid is high and ready is low. Each read pulse to the store
// is answered by exactly one read_block_valid_in two cycles later.
module block_stream_reader #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
`ifdef BLOCK_READER_ABORT_EN
    input  logic                     abort_in,
`endif
    output logic                     busy_out,
    output logic                     read_next_block_valid_out,
    input  logic [REGISTER_SIZE-1:0] read_block_in,
    input  logic                     read_block_valid_in,
    output logic [REGISTER_SIZE-1:0] block_out,
    output logic                     block_valid_out,
    input  logic                     block_ready_in,
    output logic                     block_last_out,
    output logic                     done_out,
    output logic [1:0]               state_dbg_out
);

    localparam int CW = $clog2(NUM_BLOCKS) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = OW + 2;
    localparam logic [CW-1:0] NUM_C   = CW'(NUM_BLOCKS);
    localparam logic [CW-1:0] LAST_C  = CW'(NUM_BLOCKS - 1);
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
    localparam logic [OW-1:0] FULL_C  = OW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
`ifdef BLOCK_READER_ABORT_EN
        ,
        FLUSH  = 2'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      issued_q, issued_d;
    logic [CW-1:0]      delivered_q, delivered_d;
    logic [1:0]         in_flight_q, in_flight_d;
    logic               pulse_q, pulse_d;
    logic               done_q, done_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]      count_q, count_d;
    logic [REGISTER_SIZE-1:0] mem_q [FIFO_DEPTH];

    logic fifo_valid;
    logic pop;
    logic push;
    logic ret;

    // Next-state, counters, FIFO pointers and the registered read pulse.
    // The pulse is decided one cycle ahead from the next-cycle occupancy and
    // in-flight values, so a pulse in cycle c obeys the credit rule on cycle c's counts.
    always_comb begin
        fifo_valid  = (count_q != '0);
        pop         = fifo_valid && block_ready_in;
        ret         = read_block_valid_in && (state_q != IDLE) && (in_flight_q != 2'd0);
        push        = ret && ((state_q == STREAM) || (state_q == DRAIN));

        state_d     = state_q;
        issued_d    = issued_q + CW'(pulse_q);
        delivered_d = delivered_q + CW'(pop);
        in_flight_d = in_flight_q + {1'b0, pulse_q} - {1'b0, ret};
        count_d     = count_q + OW'(push) - OW'(pop);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        done_d      = 1'b0;

        if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d     = STREAM;
                    issued_d    = '0;
                    delivered_d = '0;
                end
            end
            STREAM: begin
                if (issued_d == NUM_C) state_d = DRAIN;
            end
            DRAIN: begin
                if ((in_flight_d == 2'd0) && (count_d == '0) && (delivered_d == NUM_C)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef BLOCK_READER_ABORT_EN
            FLUSH: begin
                if ((in_flight_d == 2'd0) && (issued_d == NUM_C)) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef BLOCK_READER_ABORT_EN
        if (abort_in && ((state_q == STREAM) || (state_q == DRAIN))) begin
            state_d = FLUSH;
            done_d  = 1'b0;
        end
        // FLUSH keeps the return buffer empty; returns are dropped.
        if (state_d == FLUSH) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
`endif

        pulse_d = (state_d == STREAM) && (issued_d < NUM_C) &&
                  ((SW'(count_d) + SW'(in_flight_d)) < DEPTH_S);
`ifdef BLOCK_READER_ABORT_EN
        if (state_d == FLUSH) pulse_d = (issued_d < NUM_C);
`endif
    end

    // Control state register with asynchronous active-low clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            issued_q    <= '0;
            delivered_q <= '0;
            in_flight_q <= 2'd0;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            in_flight_q <= in_flight_d;
            pulse_q     <= pulse_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Return-buffer storage; contents are only meaningful below count_q.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= read_block_in;
    end

`ifndef SYNTHESIS
    // Issue is throttled on occupancy plus in-flight, so a push never meets a full buffer.
    push_into_full: assert property (@(posedge clk_in) disable iff (!rst_in)
                                     !(push && (count_q == FULL_C)));
`endif

    assign block_valid_out           = fifo_valid;
    assign block_out                 = fifo_valid ? mem_q[rd_ptr_q] : '0;
    assign block_last_out            = fifo_valid && (delivered_q == LAST_C);
    assign busy_out                  = (state_q != IDLE);
    assign read_next_block_valid_out = pulse_q;
    assign done_out                  = done_q;
    assign state_dbg_out             = state_q;

endmodule

// File: tb/tb_block_stream_reader.sv
// Bench for block_stream_reader: a 2-cycle-latency block store model, a
// scoreboard fed from the frame contents the bench loads into the store, and
// one task per scenario.
`timescale 1ns/1ps
module tb_block_stream_reader;

    localparam int W  = 32;
    localparam int NB = 8;
    localparam int FD = 4;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b0;
    logic         start_in = 1'b0;
    logic         abort_drv = 1'b0;
    logic         busy_out;
    logic         read_next_block_valid_out;
    logic [W-1:0] read_block_in;
    logic         read_block_valid_in;
    logic [W-1:0] block_out;
    logic         block_valid_out;
    logic         block_ready_in = 1'b0;
    logic         block_last_out;
    logic         done_out;
    logic [1:0]   state_dbg;

    // clock
    always #5 clk_in = ~clk_in;

    block_stream_reader #(
        .REGISTER_SIZE (W),
        .NUM_BLOCKS    (NB),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk_in                    (clk_in),
        .rst_in                    (rst_in),
        .start_in                  (start_in),
`ifdef BLOCK_READER_ABORT_EN
        .abort_in                  (abort_drv),
`endif
        .busy_out                  (busy_out),
        .read_next_block_valid_out (read_next_block_valid_out),
        .read_block_in             (read_block_in),
        .read_block_valid_in       (read_block_valid_in),
        .block_out                 (block_out),
        .block_valid_out           (block_valid_out),
        .block_ready_in            (block_ready_in),
        .block_last_out            (block_last_out),
        .done_out                  (done_out),
        .state_dbg_out             (state_dbg)
    );

    // Block store model: address advances on each read pulse, data returns 2 cycles later.
    logic [W-1:0] store_mem [NB];
    int           store_addr;
    logic         st_p1, st_v, inj_v = 1'b0;
    logic [W-1:0] st_d1, st_d;
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            st_p1 <= 1'b0; st_v <= 1'b0; st_d1 <= '0; st_d <= '0; store_addr <= 0;
        end else begin
            st_p1 <= read_next_block_valid_out;
            if (read_next_block_valid_out) begin
                st_d1      <= store_mem[store_addr];
                store_addr <= (store_addr + 1) % NB;
            end
            st_v <= st_p1;
            st_d <= st_d1;
        end
    end
    assign read_block_valid_in = st_v | inj_v;
    assign read_block_in       = st_d;

    // Scoreboard and per-frame logs
    logic [W-1:0] exp_q[$];
    int           exp_idx_q[$];
    int           pulse_log[$], xfer_log[$], done_log[$];
    int           total = 0, bad = 0;
    int           cyc = 0, c0 = 0;
    int           pulse_cnt, xfer_cnt, done_cnt, last_cnt, last_cyc;
    logic         prev_stall = 1'b0, prev_last = 1'b0, after_abort = 1'b0;
    logic [W-1:0] prev_data = '0;

    // One clock cycle: sample outputs at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [W-1:0] e;
        int           ei;
        @(negedge clk_in);
        if (rst_in) begin
            if (read_next_block_valid_out) begin pulse_cnt++; pulse_log.push_back(cyc - c0); end
            if (done_out) begin done_cnt++; done_log.push_back(cyc - c0); end
            if (prev_stall) begin
                total++;
                if (block_valid_out !== 1'b1 || block_out !== prev_data || block_last_out !== prev_last) begin
                    bad++;
                    $display("FAIL hold_stable: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                             block_valid_out, block_out, block_last_out, prev_data, prev_last);
                end
            end
            if (after_abort) begin
                total++;
                if (block_valid_out !== 1'b0) begin
                    bad++;
                    $display("FAIL valid_after_abort: got %0b want 0", block_valid_out);
                end
            end
            if (block_valid_out === 1'b1 && block_ready_in) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_block: got %h want no transfer", block_out);
                end else begin
                    e  = exp_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    if (block_out !== e || block_last_out !== (ei == NB - 1)) begin
                        bad++;
                        $display("FAIL block_data: idx %0d got %h last=%0b want %h last=%0b",
                                 ei, block_out, block_last_out, e, (ei == NB - 1));
                    end
                end
                xfer_cnt++;
                xfer_log.push_back(cyc - c0);
                if (block_last_out) begin last_cnt++; last_cyc = cyc - c0; end
            end
            prev_stall = (block_valid_out === 1'b1) && !block_ready_in;
            prev_data  = block_out;
            prev_last  = block_last_out;
        end else begin
            prev_stall = 1'b0;
        end
        if (abort_drv) after_abort = 1'b1;
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        pulse_log.delete(); xfer_log.delete(); done_log.delete();
        pulse_cnt = 0; xfer_cnt = 0; done_cnt = 0; last_cnt = 0; last_cyc = -1;
        after_abort = 1'b0;
    endtask

    // Load fresh random frame contents, queue the expected stream, pulse start (cycle 0).
    task automatic start_frame();
        for (int i = 0; i < NB; i++) begin
            store_mem[i] = $urandom();
            exp_q.push_back(store_mem[i]);
            exp_idx_q.push_back(i);
        end
        clear_logs();
        c0 = cyc;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (rnd_ready) block_ready_in = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL done_timeout: got no done in %0d cycles want done", budget);
        end
    endtask

    task automatic check_frame_end(input string tag);
        total++;
        if (xfer_cnt != NB || last_cnt != 1 || done_cnt != 1 || exp_q.size() != 0 || store_addr != 0) begin
            bad++;
            $display("FAIL %s_frame_end: got xfer=%0d last=%0d done=%0d left=%0d addr=%0d want %0d/1/1/0/0",
                     tag, xfer_cnt, last_cnt, done_cnt, exp_q.size(), store_addr, NB);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        #3;
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_out); end
        total++; if (block_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", block_valid_out); end
        total++; if (block_last_out !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", block_last_out); end
        total++; if (read_next_block_valid_out !== 1'b0) begin bad++; $display("FAIL rst_pulse: got %b want 0", read_next_block_valid_out); end
        total++; if (done_out !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_out); end
        total++; if (block_out !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", block_out); end
        tick(); tick();
        rst_in = 1'b1;
        tick();
    endtask

    // Full-rate frame: pulses 1..8, blocks 4..11, last at 11, done at 12.
    task automatic test_latency();
        bit ok;
        block_ready_in = 1'b1;
        start_frame();
        wait_done(40, 1'b0);
        ok = (pulse_log.size() == NB);
        for (int i = 0; i < pulse_log.size(); i++) if (pulse_log[i] != i + 1) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL lat_pulses: got n=%0d first=%0d want n=%0d first=1", pulse_log.size(), (pulse_log.size() > 0) ? pulse_log[0] : -1, NB); end
        ok = (xfer_log.size() == NB);
        for (int i = 0; i < xfer_log.size(); i++) if (xfer_log[i] != i + 4) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL lat_blocks: got n=%0d first=%0d want n=%0d first=4", xfer_log.size(), (xfer_log.size() > 0) ? xfer_log[0] : -1, NB); end
        total++;
        if (last_cyc != 11) begin bad++; $display("FAIL lat_last: got cycle %0d want 11", last_cyc); end
        total++;
        if (!(done_log.size() == 1 && done_log[0] == 12)) begin bad++; $display("FAIL lat_done: got n=%0d want one at cycle 12", done_log.size()); end
        total++;
        if (busy_out !== 1'b0) begin bad++; $display("FAIL lat_idle: got busy=%b want 0", busy_out); end
        check_frame_end("latency");
        tick();
    endtask

    task automatic test_backpressure();
        block_ready_in = 1'b0;
        start_frame();
        repeat (10) tick();
        total++;
        if (pulse_cnt != FD || xfer_cnt != 0) begin
            bad++;
            $display("FAIL bp_pulses: got pulses=%0d xfers=%0d want %0d/0", pulse_cnt, xfer_cnt, FD);
        end
        total++;
        if (block_valid_out !== 1'b1 || busy_out !== 1'b1) begin
            bad++;
            $display("FAIL bp_stalled: got valid=%b busy=%b want 1/1", block_valid_out, busy_out);
        end
        block_ready_in = 1'b1;
        wait_done(60, 1'b0);
        check_frame_end("backpressure");
        tick();
    endtask

    task automatic test_random_ready();
        for (int f = 0; f < 8; f++) begin
            start_frame();
            wait_done(300, 1'b1);
            total++;
            if (pulse_cnt != NB) begin bad++; $display("FAIL rnd_pulses: frame %0d got %0d want %0d", f, pulse_cnt, NB); end
            check_frame_end("random");
            block_ready_in = 1'b1;
            tick();
        end
    endtask

    task automatic test_restart_ignored();
        int n = 0;
        start_frame();
        while (done_cnt == 0 && n < 300) begin
            start_in = (n == 2 || n == 5);
            block_ready_in = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        start_in = 1'b0;
        total++;
        if (done_cnt == 0) begin bad++; $display("FAIL restart_timeout: got no done want done"); end
        check_frame_end("restart");
        repeat (3) tick();
        total++;
        if (busy_out !== 1'b0 || pulse_cnt != NB) begin
            bad++;
            $display("FAIL restart_idle: got busy=%b pulses=%0d want 0/%0d", busy_out, pulse_cnt, NB);
        end
    endtask

    // A stray return while idle must be dropped and must not leak into the next frame.
    task automatic test_idle_return();
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        tick();
        total++;
        if (block_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            bad++;
            $display("FAIL idle_return: got valid=%b busy=%b want 0/0", block_valid_out, busy_out);
        end
        block_ready_in = 1'b1;
        start_frame();
        wait_done(40, 1'b0);
        check_frame_end("idle_return");
        tick();
    endtask

    task automatic test_reset_midframe();
        block_ready_in = 1'b1;
        start_frame();
        repeat (5) tick();
        rst_in = 1'b0;
        #1;
        total++;
        if (busy_out !== 1'b0 || block_valid_out !== 1'b0 || block_last_out !== 1'b0 ||
            read_next_block_valid_out !== 1'b0 || done_out !== 1'b0 || block_out !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got busy=%b v=%b l=%b p=%b d=%b data=%h want all 0",
                     busy_out, block_valid_out, block_last_out, read_next_block_valid_out, done_out, block_out);
        end
        exp_q.delete();
        exp_idx_q.delete();
        tick();
        rst_in = 1'b1;
        tick();
        start_frame();
        wait_done(40, 1'b0);
        check_frame_end("after_reset");
        tick();
    endtask

`ifdef BLOCK_READER_ABORT_EN
    task automatic test_abort();
        int n = 0;
        block_ready_in = 1'b1;
        start_frame();
        while (xfer_cnt < 3 && n < 40) begin tick(); n++; end
        abort_drv = 1'b1;
        tick();
        abort_drv = 1'b0;
        exp_q.delete();
        exp_idx_q.delete();
        n = 0;
        while (busy_out && n < 40) begin tick(); n++; end
        repeat (3) tick();
        total++;
        if (pulse_cnt != NB || done_cnt != 0 || busy_out !== 1'b0 || store_addr != 0) begin
            bad++;
            $display("FAIL abort_end: got pulses=%0d done=%0d busy=%b addr=%0d want %0d/0/0/0",
                     pulse_cnt, done_cnt, busy_out, store_addr, NB);
        end
        after_abort = 1'b0;
        start_frame();
        wait_done(40, 1'b0);
        check_frame_end("after_abort");
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_random_ready();
        test_restart_ignored();
        test_idle_return();
        test_reset_midframe();
`ifdef BLOCK_READER_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
